// File: rtl/fp32_divsqrt_sequencer_if.sv
// fp32_divsqrt_sequencer_if: request, unit-side and response signals of the div/sqrt sequencer
interface fp32_divsqrt_sequencer_if #(parameter int TAG_W = 5);
  logic flush;
  logic req_valid, req_ready, req_is_sqrt;
  logic [2:0] req_rm;
  logic [32:0] req_a, req_b;
  logic [TAG_W-1:0] req_tag;
  logic ds_in_valid, ds_in_ready, ds_sqrt_op;
  logic [2:0] ds_rm;
  logic [32:0] ds_a, ds_b;
  logic ds_out_valid_div, ds_out_valid_sqrt;
  logic [32:0] ds_out;
  logic [4:0] ds_exc;
  logic resp_valid, resp_ready, resp_is_sqrt, busy;
  logic [TAG_W-1:0] resp_tag;
  logic [31:0] resp_data;
  logic [4:0] resp_exc;
  modport slave (
    input flush, req_valid, req_is_sqrt, req_rm, req_a, req_b, req_tag,
    input ds_in_ready, ds_out_valid_div, ds_out_valid_sqrt, ds_out, ds_exc, resp_ready,
    output req_ready, ds_in_valid, ds_sqrt_op, ds_rm, ds_a, ds_b,
    output resp_valid, resp_tag, resp_is_sqrt, resp_data, resp_exc, busy
  );
  modport master (
    output flush, req_valid, req_is_sqrt, req_rm, req_a, req_b, req_tag,
    output ds_in_ready, ds_out_valid_div, ds_out_valid_sqrt, ds_out, ds_exc, resp_ready,
    input req_ready, ds_in_valid, ds_sqrt_op, ds_rm, ds_a, ds_b,
    input resp_valid, resp_tag, resp_is_sqrt, resp_data, resp_exc, busy
  );
endinterface

// File: rtl/fp32_divsqrt_sequencer.sv
// fp32_divsqrt_sequencer: queues tagged div/sqrt requests, issues them one at a time and returns IEEE results
module fp32_divsqrt_sequencer #(
  parameter int DEPTH = 2,
  parameter int TAG_W = 5
) (
  input logic clk,
  input logic rst,
  fp32_divsqrt_sequencer_if.slave bus
);
  localparam int EW = 70 + TAG_W;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DRAIN} state_t;
  state_t st_q, st_d;
  logic [EW-1:0] mem_q [DEPTH];
  logic [EW-1:0] mem_d [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic sq_q, sq_d;
  logic [2:0] rm_q, rm_d;
  logic [32:0] a_q, a_d, b_q, b_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic rv_q, rv_d, rsq_q, rsq_d;
  logic [TAG_W-1:0] rtag_q, rtag_d;
  logic [31:0] rdata_q, rdata_d;
  logic [4:0] rexc_q, rexc_d;
  logic push, pop, done, cap;
  function automatic logic [31:0] rec_to_ieee(input logic [32:0] x);
    logic [8:0] e;
    logic [22:0] f;
    logic [4:0] sh;
    e = x[31:23];
    f = x[22:0];
    sh = 5'(9'd1 - e);
    return e[8:6] == 3'b000 ? {x[32], 31'b0} :
           e[8:7] == 2'b11  ? {x[32], 8'hFF, e[6] ? f : 23'b0} :
           e < 9'd130       ? {x[32], 8'h00, 23'(({1'b1, f} >> 1) >> sh)} :
                              {x[32], 8'(e - 9'd129), f};
  endfunction
  assign bus.req_ready = (cnt_q < CW'(DEPTH)) & !bus.flush;
  assign bus.ds_in_valid = st_q == ISSUE;
  assign {bus.ds_sqrt_op, bus.ds_rm, bus.ds_a, bus.ds_b} = {sq_q, rm_q, a_q, b_q};
  assign {bus.resp_valid, bus.resp_tag, bus.resp_is_sqrt, bus.resp_data, bus.resp_exc} = {rv_q, rtag_q, rsq_q, rdata_q, rexc_q};
  assign bus.busy = (cnt_q != '0) | (st_q != IDLE) | rv_q;
  always_comb begin
    push = bus.req_valid & bus.req_ready;
    done = bus.ds_out_valid_div | bus.ds_out_valid_sqrt;
    st_d = st_q;
    pop = 1'b0;
    cap = 1'b0;
    case (st_q)
      IDLE: if (cnt_q != '0 && !rv_q && !bus.flush) begin
        st_d = ISSUE;
        pop = 1'b1;
      end
      ISSUE: st_d = bus.flush ? (bus.ds_in_ready ? DRAIN : IDLE) : (bus.ds_in_ready ? WAIT : ISSUE);
      WAIT: if (bus.flush) st_d = done ? IDLE : DRAIN;
      else if (done) begin
        st_d = IDLE;
        cap = 1'b1;
      end
      DRAIN: st_d = done ? IDLE : DRAIN;
    endcase
    mem_d = mem_q;
    if (push) mem_d[wr_q] = {bus.req_is_sqrt, bus.req_rm, bus.req_a, bus.req_b, bus.req_tag};
    wr_d = bus.flush ? '0 : wr_q + PW'(push);
    rd_d = bus.flush ? '0 : rd_q + PW'(pop);
    cnt_d = bus.flush ? '0 : cnt_q + CW'(push) - CW'(pop);
    {sq_d, rm_d, a_d, b_d, tag_d} = pop ? mem_q[rd_q] : {sq_q, rm_q, a_q, b_q, tag_q};
    rv_d = !bus.flush & (cap | (rv_q & !bus.resp_ready));
    {rtag_d, rsq_d, rdata_d, rexc_d} = cap ? {tag_q, sq_q, rec_to_ieee(bus.ds_out), bus.ds_exc}
                                           : {rtag_q, rsq_q, rdata_q, rexc_q};
  end
  always_ff @(posedge clk) mem_q <= mem_d;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      st_q <= IDLE;
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
      {sq_q, rm_q, a_q, b_q, tag_q} <= '0;
      {rv_q, rtag_q, rsq_q, rdata_q, rexc_q} <= '0;
    end else begin
      st_q <= st_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
      {sq_q, rm_q, a_q, b_q, tag_q} <= {sq_d, rm_d, a_d, b_d, tag_d};
      {rv_q, rtag_q, rsq_q, rdata_q, rexc_q} <= {rv_d, rtag_d, rsq_d, rdata_d, rexc_d};
    end
endmodule

// File: doc/fp32_divsqrt_sequencer.md
# fp32_divsqrt_sequencer

Issue/retire sequencer sitting directly upstream and downstream of the FP32 recoded-format divide/square-root unit. Buffers tagged div/sqrt requests in a small FIFO and issues them one at a time into the unit's input handshake. Captures the unit's single-cycle result pulse into a backpressurable response register and converts the 33-bit recoded result to IEEE-754 binary32. Supports flushing of queued and in-flight work.

## Interface
- DEPTH, 2, request FIFO entries (power of two, >=2)
- TAG_W, 5, request/response tag width
- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high
- flush  in  1  discard all queued, in-flight and pending-response work
- req_valid / req_ready  in / out  1  request handshake
- req_is_sqrt  in  1  1 = sqrt(a), 0 = a/b
- req_rm  in  3  rounding mode, passed through
- req_a, req_b  in  33  recoded operands (b ignored for sqrt)
- req_tag  in  TAG_W  opaque tag
- ds_in_valid  out  1  issue strobe to the div/sqrt unit
- ds_in_ready  in  1  unit can accept
- ds_sqrt_op, ds_rm, ds_a, ds_b  out  1/3/33/33  issued operation
- ds_out_valid_div, ds_out_valid_sqrt  in  1  one-cycle completion pulses
- ds_out  in  33  recoded result
- ds_exc  in  5  exception flags {NV,DZ,OF,UF,NX}
- resp_valid / resp_ready  out / in  1  response handshake
- resp_tag  out  TAG_W; resp_is_sqrt  out  1; resp_data  out  32  IEEE result; resp_exc  out  5
- busy  out  1  FIFO non-empty or state != IDLE or resp_valid

## Operation
- FIFO: entry {is_sqrt, rm, a, b, tag}; req_ready = (count < DEPTH) & !flush; push on req_valid & req_ready.
- FSM states IDLE, ISSUE, WAIT, DRAIN; completion C = ds_out_valid_div | ds_out_valid_sqrt.
- IDLE: if FIFO non-empty & !resp_valid & !flush -> pop head into issue registers, ISSUE.
- ISSUE: ds_in_valid = 1. flush & ds_in_ready -> DRAIN; flush alone -> IDLE; ds_in_ready -> WAIT.
- WAIT: flush (even with C) -> DRAIN if !C, IDLE if C, result discarded; C -> capture {tag, is_sqrt, convert(ds_out), ds_exc} into response register, IDLE.
- DRAIN: C -> IDLE, result discarded. Unit cannot be aborted.
- C in IDLE/ISSUE is ignored. Either pulse completes either op type.
- Issue only when response register is empty, so a completion never finds it full; no overflow path.
- Response register holds until resp_valid & resp_ready; flush clears it.
- flush clears FIFO (count 0); flush on a push cycle rejects the push.
- Recoded->IEEE: s = x[32], e = x[31:23], f = x[22:0].
  - zero: e[8:6]=0 -> {s, 31'b0}.
  - special: e[8:7]=11; inf if !e[6] -> {s, 8'hFF, 0}; NaN if e[6] -> {s, 8'hFF, f}.
  - subnormal: e < 130, nonzero -> exponent 0, fraction = ({1,f} >> 1 >> ((1-e) mod 32))[22:0].
  - normal: exponent = (e - 129)[7:0], fraction f.

## Timing
- Reset: FIFO empty, state IDLE; ds_in_valid 0, resp_valid 0, busy 0; all data outputs 0; req_ready 1 once FIFO empty and flush low.
- ds_* and resp_* outputs are registered; req_ready is combinational from count and flush.
- Request accepted at edge T: issue registers load at edge T+1; ds_in_valid high T+1..handshake.
- Completion pulse at cycle N: resp_valid high from N+1.
- Minimum request-to-response latency is 3 cycles plus unit latency.
- Back-to-back ops: next issue loads no earlier than the edge after resp_valid & resp_ready.
- Reset mid-operation: immediate return to reset values; later unit pulses arrive in IDLE and are ignored.

## Test plan
- div a=0x0_8080_0000 (2.0), b=0x0_8000_0000 (1.0), tag 3; unit returns 0x0_8080_0000 exc 0 -> resp_data 0x40000000, resp_tag 3, resp_is_sqrt 0.
- Push 3 requests with unit stalled (ds_in_ready=0), DEPTH=2: two accepted while the FSM pops; req_ready drops when full; responses emerge in tag order.
- Conversions: recoded 0x0_E040_0000 -> 0x7FC00000; 0x1_C000_0000 -> 0xFF800000; 0x0 -> 0x0; 0x0_8000_0000 -> 0x3F800000.
- Hold resp_ready=0 for 10 cycles with 2 queued: no second ds_in_valid until response drained; resp fields stable.
- flush in WAIT, unit completes 5 cycles later: no resp_valid, FIFO empty, busy falls the cycle after the pulse; next request proceeds normally.
- flush coincident with ds_in_ready in ISSUE -> DRAIN; flush coincident with req_valid -> request rejected.
